ioctl_stream_tx: RTL

//  Driving end of the ioctl download interface: streams a byte source into ioctl_download/

---
 rtl/ioctl_tx_pkg.sv | 16 +
 rtl/ioctl_stream_tx.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/ioctl_tx_pkg.sv
// Shared types for the ioctl download driver: transfer FSM states and well-known ioctl_index values.
package ioctl_tx_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SETUP  = 3'd1,
      FETCH  = 3'd2,
      WRITE  = 3'd3,
      GAP    = 3'd4,
      FINISH = 3'd5
   } tx_state_t;

   localparam logic [7:0] IDX_ROM   = 8'd0;
   localparam logic [7:0] IDX_NVRAM = 8'd4;

endpackage

// File: rtl/ioctl_stream_tx.sv
// Drives the ioctl download bus from a byte stream, paced like the HPS (one strobe, then WR_GAP idle).
// Optional IOCTL_TX_CHECKSUM_EN adds checksum[7:0], the XOR of every byte strobed in the transfer.
module ioctl_stream_tx
   import ioctl_tx_pkg::*;
#(
   parameter int ADDR_W = 25,
   parameter int WR_GAP = 3
) (
   input  logic              clk_sys,
   input  logic              reset,
   input  logic              start,
   input  logic [7:0]        index,
   input  logic [ADDR_W-1:0] length,
   input  logic              abort,
   input  logic [7:0]        s_data,
   input  logic              s_valid,
   output logic              s_ready,
   output logic              busy,
   output logic              done,
   output logic              ioctl_download,
   output logic [7:0]        ioctl_index,
   output logic              ioctl_wr,
   output logic [ADDR_W-1:0] ioctl_addr,
   output logic [7:0]        ioctl_dout,
   input  logic              ioctl_wait
`ifdef IOCTL_TX_CHECKSUM_EN
   ,
   output logic [7:0]        checksum
`endif
);

   localparam int GAP_W = (WR_GAP > 0) ? $clog2(WR_GAP + 1) : 1;
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((WR_GAP > 0) ? WR_GAP - 1 : 0);

   tx_state_t         r_state;
   tx_state_t         w_state_next;
   logic [ADDR_W-1:0] r_len;
   logic [ADDR_W-1:0] r_cnt;
   logic [ADDR_W-1:0] r_addr;
   logic [7:0]        r_index;
   logic [7:0]        r_dout;
   logic [GAP_W-1:0]  r_gap;
   logic              r_done;
   logic [ADDR_W-1:0] w_cnt_inc;
   logic              w_gap_done;
   logic              w_take;
   logic              w_download;
   logic              w_wr;
   logic              w_s_ready;

   assign w_cnt_inc  = r_cnt + 1'b1;
   assign w_gap_done = (r_gap == GAP_LAST) && !ioctl_wait;
   // A byte is never consumed in the cycle abort is seen.
   assign w_take     = (r_state == FETCH) && s_valid && !abort;

   always_comb begin
      w_state_next = r_state;
      w_download   = 1'b0;
      w_wr         = 1'b0;
      w_s_ready    = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) w_state_next = SETUP;
         end
         SETUP: begin
            w_download = 1'b1;
            if (abort || r_len == '0) w_state_next = FINISH;
            else                      w_state_next = FETCH;
         end
         FETCH: begin
            w_download = 1'b1;
            w_s_ready  = !abort;
            if (abort)        w_state_next = FINISH;
            else if (s_valid) w_state_next = WRITE;
         end
         WRITE: begin
            w_download = 1'b1;
            w_wr       = 1'b1;
            // With no pacing gap, GAP is only entered to sit out receiver backpressure.
            if (abort)                            w_state_next = FINISH;
            else if (WR_GAP == 0 && !ioctl_wait)  w_state_next = (w_cnt_inc == r_len) ? FINISH : FETCH;
            else                                  w_state_next = GAP;
         end
         GAP: begin
            w_download = 1'b1;
            if (abort)           w_state_next = FINISH;
            else if (w_gap_done) w_state_next = (r_cnt == r_len) ? FINISH : FETCH;
         end
         FINISH: begin
            w_download   = 1'b1;
            w_state_next = IDLE;
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
         r_len   <= '0;
         r_cnt   <= '0;
         r_addr  <= '0;
         r_index <= '0;
         r_dout  <= '0;
         r_gap   <= '0;
         r_done  <= 1'b0;
`ifdef IOCTL_TX_CHECKSUM_EN
         checksum <= '0;
`endif
      end else begin
         r_state <= w_state_next;
         r_done  <= (r_state == FINISH);
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_index <= index;
                  r_len   <= length;
                  r_cnt   <= '0;
                  r_addr  <= '0;
`ifdef IOCTL_TX_CHECKSUM_EN
                  checksum <= '0;
`endif
               end
            end
            FETCH: begin
               // ioctl_addr keeps the last written address after the transfer ends.
               if (w_take) begin
                  r_dout <= s_data;
                  r_addr <= r_cnt;
               end
            end
            WRITE: begin
               r_cnt <= w_cnt_inc;
               r_gap <= '0;
`ifdef IOCTL_TX_CHECKSUM_EN
               checksum <= checksum ^ r_dout;
`endif
            end
            GAP: begin
               if (r_gap != GAP_LAST) r_gap <= r_gap + 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

   assign s_ready        = w_s_ready;
   assign busy           = (r_state != IDLE);
   assign done           = r_done;
   assign ioctl_download = w_download;
   assign ioctl_index    = r_index;
   assign ioctl_wr       = w_wr;
   assign ioctl_addr     = r_addr;
   assign ioctl_dout     = r_dout;

endmodule
